// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal transmit FIFO, selectable parity and 1/2 stop bits.
// Frames run back-to-back while the FIFO holds data; tx_done pulses at each frame end.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [15:0]                   prescale,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  // FIFO storage and pointers (one extra bit distinguishes full from empty)
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic                  full, empty, push, pop;
  logic [DATA_WIDTH-1:0] rd_data;

  // Transmitter state
  logic [2:0]            state_q, state_d;
  logic [15:0]           timer_q, timer_d;
  logic [15:0]           p_q, p_d;
  logic [15:0]           p_eff;
  logic [BW-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic                  parity_q, parity_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_second_q, stop_second_d;
  logic                  tx_done_q, tx_done_d;
  logic                  frame_end;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign s_ready = !full;
  assign push    = s_valid && !full;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  assign frame_end = (state_q == StStop) && (timer_q == 16'd0) && (!stop2_q || stop_second_q);
  assign pop       = !empty && ((state_q == StIdle) || frame_end);

  assign p_eff = (prescale == 16'd0) ? 16'd1 : prescale;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign txd        = txd_q;
  assign busy       = (state_q != StIdle);
  assign tx_done    = tx_done_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    p_d           = p_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    txd_d         = txd_q;
    parity_d      = parity_q;
    par_en_d      = par_en_q;
    stop2_d       = stop2_q;
    stop_second_d = stop_second_q;
    tx_done_d     = 1'b0;

    if (state_q != StIdle && timer_q != 16'd0) begin
      timer_d = timer_q - 16'd1;
    end else begin
      case (state_q)
        StStart: begin
          state_d   = StData;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
          timer_d   = p_q - 16'd1;
        end
        StData: begin
          timer_d = p_q - 16'd1;
          if (bit_idx_q == BW'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_d = StParity;
              txd_d   = parity_q;
            end else begin
              state_d       = StStop;
              txd_d         = 1'b1;
              stop_second_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
        StParity: begin
          state_d       = StStop;
          txd_d         = 1'b1;
          stop_second_d = 1'b0;
          timer_d       = p_q - 16'd1;
        end
        StStop: begin
          if (stop2_q && !stop_second_q) begin
            stop_second_d = 1'b1;
            timer_d       = p_q - 16'd1;
          end else begin
            tx_done_d = 1'b1;
            state_d   = StIdle;
            txd_d     = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // A pop overrides the end-of-frame return to idle so frames chain without a gap
    if (pop) begin
      state_d  = StStart;
      txd_d    = 1'b0;
      shift_d  = rd_data;
      parity_d = (^rd_data) ^ parity_mode[1];
      par_en_d = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      stop2_d  = stop2;
      p_d      = p_eff;
      timer_d  = p_eff - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      p_q           <= 16'd1;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      txd_q         <= 1'b1;
      parity_q      <= 1'b0;
      par_en_q      <= 1'b0;
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
      tx_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      p_q           <= p_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      txd_q         <= txd_d;
      parity_q      <= parity_d;
      par_en_q      <= par_en_d;
      stop2_q       <= stop2_d;
      stop_second_q <= stop_second_d;
      tx_done_q     <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame bit patterns, chaining, FIFO full, prescale and reset.
module tb_uart_tx_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned FD = 4;

  logic                   clk;
  logic                   rst_n;
  logic [DW-1:0]          s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic [15:0]            prescale;
  logic [1:0]             parity_mode;
  logic                   stop2;
  logic                   txd;
  logic                   busy;
  logic                   tx_done;
  logic [$clog2(FD):0]    fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_fifo #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .prescale   (prescale),
    .parity_mode(parity_mode),
    .stop2      (stop2),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; the word is taken on the following rising edge
  task automatic push(input logic [DW-1:0] d);
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (txd !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check({tag, " start timeout"}, {31'd0, txd}, 32'd0);
  endtask

  // First sample is taken at the current falling edge (first cycle of the start bit)
  task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits,
                             input int p);
    for (int b = 0; b < nbits; b++) begin
      logic ok;
      ok = 1'b1;
      for (int c = 0; c < p; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (txd !== bits[b] || busy !== 1'b1) ok = 1'b0;
      end
      check($sformatf("%s bit%0d", tag, b), {31'd0, ok}, 32'd1);
    end
    @(negedge clk);
    check({tag, " tx_done"}, {31'd0, tx_done}, 32'd1);
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    check({tag, " idle tx_done"}, {31'd0, tx_done}, 32'd0);
    check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    check({tag, " idle txd"}, {31'd0, txd}, 32'd1);
  endtask

  initial begin
    logic [15:0] exp_bits;
    logic        ok;
    rst_n       = 1'b0;
    s_data      = '0;
    s_valid     = 1'b0;
    prescale    = 16'd4;
    parity_mode = 2'b01;
    stop2       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst txd", {31'd0, txd}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst tx_done", {31'd0, tx_done}, 32'd0);
    check("rst s_ready", {31'd0, s_ready}, 32'd1);
    check("rst fifo_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA5, even parity: 0 | 1,0,1,0,0,1,0,1 | 0 | 1
    fork
      push(8'hA5);
      begin wait_start("even"); check_frame("even", 16'h054A, 11, 4); end
    join
    idle_after("even");

    parity_mode = 2'b10;
    fork
      push(8'hA5);
      begin wait_start("odd"); check_frame("odd", 16'h074A, 11, 4); end
    join
    idle_after("odd");

    parity_mode = 2'b00;
    stop2       = 1'b1;
    fork
      push(8'hA5);
      begin wait_start("stop2"); check_frame("stop2", 16'h074A, 11, 4); end
    join
    idle_after("stop2");

    // Three back-to-back frames, even parity, prescale 2
    prescale    = 16'd2;
    parity_mode = 2'b01;
    stop2       = 1'b0;
    fork
      begin push(8'h01); push(8'h02); push(8'h03); end
      begin
        wait_start("b2b");
        check_frame("b2b0", 16'h0602, 11, 2);
        check_frame("b2b1", 16'h0604, 11, 2);
        check_frame("b2b2", 16'h0406, 11, 2);
      end
    join
    idle_after("b2b");

    // FIFO fill: valid held six cycles, five words accepted
    prescale    = 16'd100;
    parity_mode = 2'b00;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          s_data  = DW'(8'h10 + i);
          s_valid = 1'b1;
          @(negedge clk);
        end
        s_valid = 1'b0;
        check("full fifo_count", 32'(fifo_count), 32'd4);
        check("full s_ready", {31'd0, s_ready}, 32'd0);
      end
      begin wait_start("full"); check_frame("full0", 16'h0220, 10, 100); end
    join
    for (int i = 1; i < 5; i++) begin
      exp_bits = 16'h0200 | (16'(8'h10 + i) << 1);
      check_frame($sformatf("full%0d", i), exp_bits, 10, 100);
    end
    idle_after("full");

    // prescale 0 behaves as 1
    prescale = 16'd0;
    fork
      push(8'h5A);
      begin wait_start("p0"); check_frame("p0", 16'h02B4, 10, 1); end
    join
    idle_after("p0");

    // prescale change mid-frame applies to the next frame only
    prescale = 16'd4;
    fork
      begin push(8'hC3); push(8'h3C); end
      begin
        wait_start("pchg");
        check_frame("pchg0", 16'h0386, 10, 4);
        check_frame("pchg1", 16'h0278, 10, 8);
      end
      begin repeat (10) @(negedge clk); prescale = 16'd8; end
    join
    idle_after("pchg");

    // Reset mid-frame with three words queued
    prescale = 16'd4;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    check("rstmid fifo_count pre", 32'(fifo_count), 32'd3);
    repeat (8) @(negedge clk);
    check("rstmid txd pre", {31'd0, txd}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid txd", {31'd0, txd}, 32'd1);
    check("rstmid busy", {31'd0, busy}, 32'd0);
    check("rstmid fifo_count", 32'(fifo_count), 32'd0);
    check("rstmid s_ready", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_count !== '0) ok = 1'b0;
    end
    check("rstmid quiet", {31'd0, ok}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
